// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: FSM state encoding, NOP word, default reset PC.
package riscv_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_EXEC = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_register.sv
// 32-bit enable-load program-counter register; loads d on the edge where load is high.
// One-cycle load latency, no backpressure; async active-low reset to RESET_PC.
module pc_register
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] d,
   output logic [31:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_PC;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register + REQ/WAIT/EXEC fetch sequencer; min 3 cycles/instr, stalls on imem_gnt, imem_rsp_valid, mem_stall.
// Optional PC_ALIGN_CHECK_EN adds misalign_err and blocks retire on an unaligned PC_next.
module pc_fetch_ctrl
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PC_next,
   input  logic        mem_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] PC,
   output logic [31:0] Instr,
   output logic        instr_valid,
   output logic        retire
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic        misalign_err
`endif
);

   fetch_state_t state;
   logic         misaligned;

`ifdef PC_ALIGN_CHECK_EN
   assign misaligned = (PC_next[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // instr_valid is high exactly in S_EXEC, so retire only needs the stall/alignment terms.
   assign retire    = instr_valid && !mem_stall && !misaligned;
   assign imem_addr = PC;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (retire),
      .d     (PC_next),
      .q     (PC)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         Instr       <= NOP_INSTR;
`ifdef PC_ALIGN_CHECK_EN
         misalign_err <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_REQ;
               imem_req <= 1'b1;
            end
            S_REQ: begin
               if (imem_gnt) begin
                  state    <= S_WAIT;
                  imem_req <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  state       <= S_EXEC;
                  Instr       <= imem_rsp_data;
                  instr_valid <= 1'b1;
               end
            end
            S_EXEC: begin
               if (retire) begin
                  state       <= S_REQ;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
               end
`ifdef PC_ALIGN_CHECK_EN
               else if (!mem_stall) begin
                  misalign_err <= 1'b1;
               end
`endif
            end
            default: begin
               state       <= S_IDLE;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a transaction-level reference model checked every cycle.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_next = '0;
   logic        mem_stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        retire;
`ifdef PC_ALIGN_CHECK_EN
   logic        misalign_err;
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .PC_next        (pc_next),
      .mem_stall      (mem_stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .PC             (pc),
      .Instr          (instr),
      .instr_valid    (instr_valid),
      .retire         (retire)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .misalign_err   (misalign_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: an instruction is "fetching" (request not yet granted), "in flight"
   // (granted, awaiting data) or "held" (data present, waiting to retire).
   bit          m_started = 1'b0;
   bit          m_fetching = 1'b0;
   bit          m_inflight = 1'b0;
   bit          m_held = 1'b0;
   bit          m_err = 1'b0;
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_instr = NOP;

   function automatic bit m_bad_target(input logic [31:0] tgt);
      return ALIGN_CHECK && (tgt % 4 != 0);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_started  <= 1'b0;
         m_fetching <= 1'b0;
         m_inflight <= 1'b0;
         m_held     <= 1'b0;
         m_err      <= 1'b0;
         m_pc       <= RST_PC;
         m_instr    <= NOP;
      end else if (!m_started) begin
         m_started  <= 1'b1;
         m_fetching <= 1'b1;
      end else if (m_fetching) begin
         if (imem_gnt) begin
            m_fetching <= 1'b0;
            m_inflight <= 1'b1;
         end
      end else if (m_inflight) begin
         if (imem_rsp_valid) begin
            m_instr    <= imem_rsp_data;
            m_inflight <= 1'b0;
            m_held     <= 1'b1;
         end
      end else if (m_held && !mem_stall) begin
         if (m_bad_target(pc_next)) begin
            m_err <= 1'b1;
         end else begin
            m_pc       <= pc_next;
            m_held     <= 1'b0;
            m_fetching <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_req",   {31'd0, imem_req},    {31'd0, m_fetching});
         chk("model_addr",  imem_addr,            m_pc);
         chk("model_pc",    pc,                   m_pc);
         chk("model_instr", instr,                m_instr);
         chk("model_valid", {31'd0, instr_valid}, {31'd0, m_held});
         chk("model_retire", {31'd0, retire},
             {31'd0, m_held && !mem_stall && !m_bad_target(pc_next)});
`ifdef PC_ALIGN_CHECK_EN
         chk("model_misalign", {31'd0, misalign_err}, {31'd0, m_err});
`endif
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset values while held in reset.
      step();
      step();
      chk("rst_pc",    pc,                   RST_PC);
      chk("rst_addr",  imem_addr,            RST_PC);
      chk("rst_instr", instr,                NOP);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req",   {31'd0, imem_req},    32'd0);
      chk("rst_retire", {31'd0, retire},     32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Back-to-back fetches: grant and response immediate, PC_next = PC + 4.
      imem_gnt       = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0050_0093;
      for (int i = 0; i < 9; i++) begin
         step();
         pc_next = pc + 32'd4;
         if (i == 0) begin
            chk("t1_req_c1",  {31'd0, imem_req}, 32'd1);
            chk("t1_addr_c1", imem_addr, 32'h0);
         end
         if (i == 2) begin
            chk("t1_instr_c3",  instr, 32'h0050_0093);
            chk("t1_valid_c3",  {31'd0, instr_valid}, 32'd1);
            chk("t1_retire_c3", {31'd0, retire}, 32'd1);
         end
         if (i == 3) chk("t1_addr_c4", imem_addr, 32'h4);
         if (i == 6) chk("t1_addr_c7", imem_addr, 32'h8);
      end
      imem_gnt       = 1'b0;
      imem_rsp_valid = 1'b0;
      pc_next        = 32'h0;
      do_reset();

      // Grant withheld 4 cycles, with a spurious response while requesting.
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         chk("t2_req_hold",  {31'd0, imem_req}, 32'd1);
         chk("t2_addr_hold", imem_addr, 32'h0);
         step();
      end
      chk("t2_req_hold5", {31'd0, imem_req}, 32'd1);
      chk("t4_instr_unchanged", instr, NOP);
      imem_rsp_valid = 1'b0;
      imem_gnt       = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk("t2_req_drop", {31'd0, imem_req}, 32'd0);

      // mem_stall for 3 cycles in EXEC, then retire to 0x40.
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00A0_0113;
      mem_stall      = 1'b1;
      pc_next        = 32'h40;
      step();
      imem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_valid_stall",  {31'd0, instr_valid}, 32'd1);
         chk("t3_pc_stall",     pc, 32'h0);
         chk("t3_retire_stall", {31'd0, retire}, 32'd0);
         step();
      end
      chk("t3_valid_c4", {31'd0, instr_valid}, 32'd1);
      mem_stall = 1'b0;
      #1;
      chk("t3_retire", {31'd0, retire}, 32'd1);
      step();
      chk("t3_pc_40",   pc, 32'h40);
      chk("t3_addr_40", imem_addr, 32'h40);
      chk("t3_instr",   instr, 32'h00A0_0113);

      // Asynchronous reset while waiting for the response.
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_pc_rst",    pc, RST_PC);
      chk("t5_valid_rst", {31'd0, instr_valid}, 32'd0);
      chk("t5_req_rst",   {31'd0, imem_req}, 32'd0);
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1111_1111;
      step();
      rst_n = 1'b1;
      step();
      imem_rsp_valid = 1'b0;
      chk("t5_instr_ignored", instr, NOP);
      chk("t5_refetch_req",   {31'd0, imem_req}, 32'd1);
      chk("t5_refetch_addr",  imem_addr, 32'h0);
      imem_gnt = 1'b1;
      step();
      imem_gnt       = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0050_0093;
      step();
      imem_rsp_valid = 1'b0;
      chk("t5_instr_new", instr, 32'h0050_0093);

      // Unaligned next PC.
      pc_next = 32'h102;
`ifdef PC_ALIGN_CHECK_EN
      #1;
      chk("t6_retire_blocked", {31'd0, retire}, 32'd0);
      step();
      chk("t6_misalign", {31'd0, misalign_err}, 32'd1);
      chk("t6_pc_held",  pc, 32'h0);
      chk("t6_valid",    {31'd0, instr_valid}, 32'd1);
`else
      #1;
      chk("t6_retire", {31'd0, retire}, 32'd1);
      step();
      chk("t6_pc_102",   pc, 32'h102);
      chk("t6_addr_102", imem_addr, 32'h102);
      chk("t6_req",      {31'd0, imem_req}, 32'd1);
`endif
      step();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
